wb_retire_queue: RTL and testbench

- Parametrised successor to the single-register writeback stage.
- Buffers up to DEPTH completed instructions from MEM in a circular queue, retires one per cycle to the register file, and supports hold and flush.
- Provides two forwarding lookup ports that search pending entries, youngest first, so ID can bypass data still waiting to be written.
- Maintains a retired-instruction counter.
- Sits between the MEM stage and the register file / ID bypass network.

---
 rtl/wb_retire_queue_pkg.sv | 24 ++
 rtl/wb_fwd_lookup.sv | 34 +++
 rtl/wb_retire_queue.sv | 126 ++++++++++++
 tb/tb_wb_retire_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_retire_queue_pkg.sv
// Shared entry layout for the writeback retire queue. MEM packs entries in this
// bit order: {rf_we, rd, data, exc}, with exc in bit 0.
package wb_retire_queue_pkg;

  localparam int WB_EXC_BIT  = 0;
  localparam int WB_DATA_LSB = 1;

  function automatic int wb_entry_width(input int reg_aw, input int data_w);
    return 1 + reg_aw + data_w + 1;
  endfunction

  function automatic int wb_rd_lsb(input int data_w);
    return WB_DATA_LSB + data_w;
  endfunction

  function automatic int wb_we_bit(input int reg_aw, input int data_w);
    return wb_rd_lsb(data_w) + reg_aw;
  endfunction

  function automatic int wb_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_fwd_lookup.sv
// Priority search over the queue entries for one forwarding port; the entry
// nearest wr_ptr (youngest) wins.
module wb_fwd_lookup #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int PW     = 1
) (
  input  logic [DEPTH-1:0]        cand,
  input  logic [DEPTH*REG_AW-1:0] rd_flat,
  input  logic [DEPTH*DATA_W-1:0] data_flat,
  input  logic [PW-1:0]           wr_ptr,
  input  logic [REG_AW-1:0]       ra,
  output logic                    hit,
  output logic [DATA_W-1:0]       data
);

  logic [PW-1:0] idx;

  // Walk oldest-to-youngest so the last match written is the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - PW'(k);
      if (cand[idx] && (rd_flat[idx*REG_AW +: REG_AW] == ra) && (ra != '0)) begin
        hit  = 1'b1;
        data = data_flat[idx*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// Writeback retire queue: buffers completed MEM results, retires one per cycle
// to the register file and forwards pending data to ID on two lookup ports.
module wb_retire_queue
  import wb_retire_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_allow,
  input  logic              in_rf_we,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_exc,
  input  logic              hold,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [REG_AW-1:0] ra0,
  input  logic [REG_AW-1:0] ra1,
  output logic              fwd_hit0,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data0,
  output logic [DATA_W-1:0] fwd_data1,
  output logic              empty,
  output logic [CNT_W-1:0]  retire_count
);

  localparam int PW    = wb_ptr_width(DEPTH);
  localparam int CW    = PW + 1;
  localparam int EW    = wb_entry_width(REG_AW, DATA_W);
  localparam int RD_L  = wb_rd_lsb(DATA_W);
  localparam int WE_B  = wb_we_bit(REG_AW, DATA_W);

  logic [EW-1:0]          mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   push;
  logic                   pop;
  logic [EW-1:0]          head;
  logic [DEPTH-1:0]       ent_valid;
  logic [DEPTH-1:0]       ent_cand;
  logic [DEPTH*REG_AW-1:0] rd_flat;
  logic [DEPTH*DATA_W-1:0] data_flat;

  assign in_allow = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = in_valid && in_allow && !flush;
  assign pop      = (count != '0) && !hold && !flush;

  assign head     = mem[rd_ptr];
  assign rf_waddr = head[RD_L +: REG_AW];
  assign rf_wdata = head[WB_DATA_LSB +: DATA_W];
  assign rf_we    = pop && head[WE_B] && !head[WB_EXC_BIT] && (rf_waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      retire_count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr       <= rd_ptr + PW'(1);
        retire_count <= retire_count + CNT_W'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry payload needs no reset; validity comes from count and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_rf_we, in_rd, in_data, in_exc};
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] age;
    assign age          = PW'(i) - rd_ptr;
    assign ent_valid[i] = ({1'b0, age} < count);
    assign ent_cand[i]  = ent_valid[i] && mem[i][WE_B] && !mem[i][WB_EXC_BIT];
    assign rd_flat[i*REG_AW +: REG_AW]   = mem[i][RD_L +: REG_AW];
    assign data_flat[i*DATA_W +: DATA_W] = mem[i][WB_DATA_LSB +: DATA_W];
  end

  wb_fwd_lookup #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH),
    .PW     (PW)
  ) u_fwd0 (
    .cand      (ent_cand),
    .rd_flat   (rd_flat),
    .data_flat (data_flat),
    .wr_ptr    (wr_ptr),
    .ra        (ra0),
    .hit       (fwd_hit0),
    .data      (fwd_data0)
  );

  wb_fwd_lookup #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH),
    .PW     (PW)
  ) u_fwd1 (
    .cand      (ent_cand),
    .rd_flat   (rd_flat),
    .data_flat (data_flat),
    .wr_ptr    (wr_ptr),
    .ra        (ra1),
    .hit       (fwd_hit1),
    .data      (fwd_data1)
  );

endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: a default build and a CNT_W=4 build share stimulus
// and are checked against a queue-based reference model plus a directed table.
module tb_wb_retire_queue;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_rf_we, in_exc, hold, flush;
  logic [AW-1:0] in_rd, ra0, ra1;
  logic [DW-1:0] in_data;

  logic          in_allow, rf_we, fwd_hit0, fwd_hit1, empty;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata, fwd_data0, fwd_data1;
  logic [63:0]   retire_count;

  logic          w_in_allow, w_rf_we, w_fwd_hit0, w_fwd_hit1, w_empty;
  logic [AW-1:0] w_rf_waddr;
  logic [DW-1:0] w_rf_wdata, w_fwd_data0, w_fwd_data1;
  logic [3:0]    w_retire_count;

  wb_retire_queue #(.DATA_W(DW), .REG_AW(AW), .DEPTH(2), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_allow(in_allow),
    .in_rf_we(in_rf_we), .in_rd(in_rd), .in_data(in_data), .in_exc(in_exc),
    .hold(hold), .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .ra0(ra0), .ra1(ra1), .fwd_hit0(fwd_hit0),
    .fwd_hit1(fwd_hit1), .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
    .empty(empty), .retire_count(retire_count)
  );

  wb_retire_queue #(.DATA_W(DW), .REG_AW(AW), .DEPTH(2), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_allow(w_in_allow),
    .in_rf_we(in_rf_we), .in_rd(in_rd), .in_data(in_data), .in_exc(in_exc),
    .hold(hold), .flush(flush), .rf_we(w_rf_we), .rf_waddr(w_rf_waddr),
    .rf_wdata(w_rf_wdata), .ra0(ra0), .ra1(ra1), .fwd_hit0(w_fwd_hit0),
    .fwd_hit1(w_fwd_hit1), .fwd_data0(w_fwd_data0), .fwd_data1(w_fwd_data1),
    .empty(w_empty), .retire_count(w_retire_count)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          exc;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] mcnt;

  typedef struct {
    logic v, we; logic [AW-1:0] rd; logic [DW-1:0] d; logic exc, h, f;
    logic [AW-1:0] a0, a1;
    logic e_allow, e_empty, e_we; logic [AW-1:0] e_waddr; logic [DW-1:0] e_wdata;
    logic e_hit0; logic [DW-1:0] e_fd0; logic e_hit1; logic [63:0] e_cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW:0] mfwd(input logic [AW-1:0] ra);
    logic [DW:0] r;
    r = '0;
    if (ra != '0)
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].we && !mq[i].exc && mq[i].rd == ra) r = {1'b1, mq[i].data};
    return r;
  endfunction

  task automatic drive(input logic v, we, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                       input logic exc, h, f, input logic [AW-1:0] a0, a1);
    in_valid = v; in_rf_we = we; in_rd = rd; in_data = d; in_exc = exc;
    hold = h; flush = f; ra0 = a0; ra1 = a1;
    #1;
  endtask

  // Compare both builds against the model, then advance one clock.
  task automatic step();
    logic m_allow, push, pop, m_we;
    logic [DW:0] f0, f1;
    ent_t hd, e;
    m_allow = (mq.size() < 2);
    pop  = (mq.size() != 0) && !hold && !flush;
    push = in_valid && m_allow && !flush;
    hd   = (mq.size() != 0) ? mq[0] : '0;
    m_we = pop && hd.we && !hd.exc && (hd.rd != '0);
    f0 = mfwd(ra0);
    f1 = mfwd(ra1);
    chk("in_allow", in_allow, m_allow);
    chk("w_in_allow", w_in_allow, m_allow);
    chk("empty", empty, mq.size() == 0);
    chk("w_empty", w_empty, mq.size() == 0);
    chk("rf_we", rf_we, m_we);
    chk("w_rf_we", w_rf_we, m_we);
    if (m_we) begin
      chk("rf_waddr", rf_waddr, hd.rd);
      chk("rf_wdata", rf_wdata, hd.data);
      chk("w_rf_wdata", {w_rf_waddr, w_rf_wdata}, {hd.rd, hd.data});
    end
    chk("fwd0", {fwd_hit0, fwd_data0}, f0);
    chk("fwd1", {fwd_hit1, fwd_data1}, f1);
    chk("w_fwd0", {w_fwd_hit0, w_fwd_data0}, f0);
    chk("w_fwd1", {w_fwd_hit1, w_fwd_data1}, f1);
    chk("retire_count", retire_count, mcnt);
    chk("w_retire_count", w_retire_count, mcnt[3:0]);
    e.we = in_rf_we; e.rd = in_rd; e.data = in_data; e.exc = in_exc;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    if (pop) mcnt = mcnt + 64'd1;
    @(negedge clk);
  endtask

  task automatic tbl_check(input int n);
    vec_t t;
    t = tbl[n];
    chk($sformatf("tbl%0d_allow", n), in_allow, t.e_allow);
    chk($sformatf("tbl%0d_empty", n), empty, t.e_empty);
    chk($sformatf("tbl%0d_rf_we", n), rf_we, t.e_we);
    if (t.e_we) chk($sformatf("tbl%0d_wr", n), {rf_waddr, rf_wdata}, {t.e_waddr, t.e_wdata});
    chk($sformatf("tbl%0d_fwd0", n), {fwd_hit0, fwd_data0}, {t.e_hit0, t.e_fd0});
    chk($sformatf("tbl%0d_hit1", n), fwd_hit1, t.e_hit1);
    chk($sformatf("tbl%0d_cnt", n), retire_count, t.e_cnt);
  endtask

  initial begin
    //            v we rd data          exc h f a0 a1 | allow empty we waddr wdata        hit0 fd0           hit1 cnt
    tbl[0]  = '{1,1,5,32'hDEADBEEF,0,0,0,5,0, 1,1,0,0,0,            0,0,            0,1-1};
    tbl[1]  = '{0,0,0,0,           0,0,0,5,0, 1,0,1,5,32'hDEADBEEF, 1,32'hDEADBEEF, 0,0};
    tbl[2]  = '{0,0,0,0,           0,0,0,5,0, 1,1,0,0,0,            0,0,            0,1};
    tbl[3]  = '{1,1,3,32'h11,      0,1,0,3,0, 1,1,0,0,0,            0,0,            0,1};
    tbl[4]  = '{1,1,3,32'h22,      0,1,0,3,0, 1,0,0,0,0,            1,32'h11,       0,1};
    tbl[5]  = '{1,1,9,32'h33,      0,1,0,3,0, 0,0,0,0,0,            1,32'h22,       0,1};
    tbl[6]  = '{0,0,0,0,           0,0,0,3,0, 0,0,1,3,32'h11,       1,32'h22,       0,1};
    tbl[7]  = '{0,0,0,0,           0,0,0,3,0, 1,0,1,3,32'h22,       1,32'h22,       0,2};
    tbl[8]  = '{1,1,7,32'h77,      1,0,0,7,7, 1,1,0,0,0,            0,0,            0,3};
    tbl[9]  = '{0,0,0,0,           0,1,0,7,7, 1,0,0,0,0,            0,0,            0,3};
    tbl[10] = '{0,0,0,0,           0,0,0,7,7, 1,0,0,0,0,            0,0,            0,3};
    tbl[11] = '{0,0,0,0,           0,0,0,7,7, 1,1,0,0,0,            0,0,            0,4};
    tbl[12] = '{1,1,4,32'h44,      0,1,0,4,0, 1,1,0,0,0,            0,0,            0,4};
    tbl[13] = '{1,1,6,32'h66,      0,1,0,4,0, 1,0,0,0,0,            1,32'h44,       0,4};
    tbl[14] = '{1,1,8,32'h88,      0,1,1,0,0, 0,0,0,0,0,            0,0,            0,4};
    tbl[15] = '{0,0,0,0,           0,0,0,0,0, 1,1,0,0,0,            0,0,            0,4};
    tbl[16] = '{1,1,2,32'h2,       0,0,1,2,0, 1,1,0,0,0,            0,0,            0,4};
    tbl[17] = '{0,0,0,0,           0,0,0,2,0, 1,1,0,0,0,            0,0,            0,4};

    mcnt = '0;
    rst = 1'b1;
    in_valid = 0; in_rf_we = 0; in_rd = '0; in_data = '0; in_exc = 0;
    hold = 0; flush = 0; ra0 = 5'd5; ra1 = 5'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_allow", in_allow, 1'b1);
    chk("rst_empty", {empty, w_empty}, 2'b11);
    chk("rst_rf_we", {rf_we, w_rf_we}, 2'b00);
    chk("rst_hit", {fwd_hit0, fwd_hit1}, 2'b00);
    chk("rst_cnt", retire_count, 64'd0);

    for (int n = 0; n < 18; n++) begin
      drive(tbl[n].v, tbl[n].we, tbl[n].rd, tbl[n].d, tbl[n].exc,
            tbl[n].h, tbl[n].f, tbl[n].a0, tbl[n].a1);
      tbl_check(n);
      step();
    end

    // Streaming push/pop pairs wrap both pointers several times.
    drive(1, 1, 5'd10, 32'hA000_0000, 0, 0, 0, 5'd10, 5'd0);
    step();
    for (int k = 1; k <= 10; k++) begin
      drive(1, 1, 5'(k + 10), 32'hA000_0000 + k, 0, 0, 0, 5'(k + 9), 5'(k + 10));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 5'd20, 5'd0);
    step();

    // Bring the narrow counter to its terminal value, then one more pop wraps it.
    drive(1, 1, 5'd1, 32'h1, 0, 0, 0, 5'd1, 5'd0);
    step();
    for (int k = 0; k < 40 && mcnt[3:0] != 4'hF; k++) begin
      drive(1, 1, 5'd1, $urandom, 0, 0, 0, 5'd1, 5'd0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    chk("cnt_wrap", w_retire_count, 4'd0);
    chk("cnt_wide", retire_count[7:0], 8'd16);

    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 4) != 0, $urandom % 2, 5'($urandom_range(0, 7)), $urandom,
            ($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 16) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end

    // Reset with entries pending clears the queue.
    drive(1, 1, 5'd3, 32'h55, 0, 1, 0, 5'd3, 5'd0);
    step();
    drive(1, 1, 5'd4, 32'h66, 0, 1, 0, 5'd3, 5'd0);
    step();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, 5'd3, 5'd4);
    @(posedge clk);
    mq.delete();
    mcnt = '0;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd4);
    chk("mid_rst_empty", empty, 1'b1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
